// File: rtl/mem_access_unit_pkg.sv
// Shared types and widths for the multicycle memory access unit.
package mem_access_unit_pkg;

    localparam int unsigned AddrW = 16;
    localparam int unsigned DataW = 16;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StDone   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OpFetch = 2'd0,
        OpRead  = 2'd1,
        OpWrite = 2'd2
    } op_e;

    // A store takes priority over the fetch/data selection.
    function automatic op_e decode_op(logic write_en, logic is_fetch);
        if (write_en) begin
            return OpWrite;
        end else if (is_fetch) begin
            return OpFetch;
        end
        return OpRead;
    endfunction

endpackage

// File: rtl/mem_access_unit_reg.sv
// Shared enable-loaded register with asynchronous active-low reset.
module mem_access_unit_reg #(
    parameter int unsigned Width = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] q_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= '0;
        end else if (en_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/mem_access_unit.sv
// One memory transaction per start pulse; reads land in IR or MDR.
// Optional access timeout with sticky err_o when MEM_TIMEOUT_EN is defined.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = AddrW,
    parameter int unsigned DATA_W = DataW
`ifdef MEM_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 15
`endif
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              start_i,
    input  logic              is_fetch_i,
    input  logic              write_en_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ready_i,
    output logic [DATA_W-1:0] ir_o,
    output logic [DATA_W-1:0] mdr_o,
`ifdef MEM_TIMEOUT_EN
    output logic              err_o,
`endif
    output logic              busy_o,
    output logic              done_o
);

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              ir_en, mdr_en;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ir_en   = 1'b0;
        mdr_en  = 1'b0;
`ifdef MEM_TIMEOUT_EN
        cnt_d   = '0;
        err_d   = err_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    op_d    = decode_op(write_en_i, is_fetch_i);
                    addr_d  = addr_i;
                    wdata_d = wr_data_i;
                    state_d = StAccess;
                end
            end
            StAccess: begin
`ifdef MEM_TIMEOUT_EN
                cnt_d = cnt_q + 1'b1;
`endif
                if (mem_ready_i) begin
                    ir_en   = (op_q == OpFetch);
                    mdr_en  = (op_q == OpRead);
                    state_d = StDone;
                end
`ifdef MEM_TIMEOUT_EN
                // Ready on the final allowed cycle wins over the timeout.
                else if (cnt_q == CntW'(TIMEOUT_CYC - 1)) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end
`endif
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            op_q    <= OpFetch;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`endif

    mem_access_unit_reg #(
        .Width(DATA_W)
    ) u_ir (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .en_i(ir_en),
        .d_i(mem_rdata_i),
        .q_o(ir_o)
    );

    mem_access_unit_reg #(
        .Width(DATA_W)
    ) u_mdr (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .en_i(mdr_en),
        .d_i(mem_rdata_i),
        .q_o(mdr_o)
    );

    assign mem_req_o   = (state_q == StAccess);
    assign mem_we_o    = mem_req_o && (op_q == OpWrite);
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign done_o      = (state_q == StDone);
    assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: vector table, corner sequences, random traffic.
module tb_mem_access_unit;

    localparam int TMO = 15;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [15:0] addr_i;
    logic        start_i;
    logic        is_fetch_i;
    logic        write_en_i;
    logic [15:0] wr_data_i;
    logic [15:0] mem_addr_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [15:0] mem_wdata_o;
    logic [15:0] mem_rdata_i;
    logic        mem_ready_i;
    logic [15:0] ir_o;
    logic [15:0] mdr_o;
    logic        busy_o;
    logic        done_o;
`ifdef MEM_TIMEOUT_EN
    logic        err_o;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: what IR/MDR must hold after completed accesses.
    logic [15:0] exp_ir = '0;
    logic [15:0] exp_mdr = '0;

    typedef struct {
        logic        wr;
        logic        fetch;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        int          waits;     // <0: never ready
        bit          poke;      // extra start while busy
        bit          idle_rdy;  // mem_ready pulse while idle
        logic [15:0] exp_ir;
        logic [15:0] exp_mdr;
    } vec_t;

    vec_t tbl[4];

    mem_access_unit u_dut (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .addr_i(addr_i),
        .start_i(start_i),
        .is_fetch_i(is_fetch_i),
        .write_en_i(write_en_i),
        .wr_data_i(wr_data_i),
        .mem_addr_o(mem_addr_o),
        .mem_req_o(mem_req_o),
        .mem_we_o(mem_we_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i),
        .mem_ready_i(mem_ready_i),
        .ir_o(ir_o),
        .mdr_o(mdr_o),
`ifdef MEM_TIMEOUT_EN
        .err_o(err_o),
`endif
        .busy_o(busy_o),
        .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_txn(input vec_t v, input string name);
        int cyc;
        int reqs;
        int dones;
        int done_cyc;
        int exp_reqs;
        cyc      = 0;
        reqs     = 0;
        dones    = 0;
        done_cyc = -1;
        exp_reqs = (v.waits < 0) ? TMO : v.waits + 1;
        @(negedge clk_i);
        if (v.idle_rdy) begin
            mem_ready_i = 1'b1;
            mem_rdata_i = ~v.rdata;
            @(negedge clk_i);
            mem_ready_i = 1'b0;
        end
        addr_i     = v.addr;
        wr_data_i  = v.wdata;
        write_en_i = v.wr;
        is_fetch_i = v.fetch;
        start_i    = 1'b1;
        @(negedge clk_i);
        start_i   = 1'b0;
        addr_i    = ~v.addr;
        wr_data_i = ~v.wdata;
        cyc       = 1;
        while (done_cyc < 0 && cyc <= exp_reqs + 4) begin
            mem_ready_i = 1'b0;
            mem_rdata_i = $urandom_range(0, 16'hFFFF);
            if (mem_req_o) begin
                reqs++;
                chk({name, "_addr"}, mem_addr_o, v.addr);
                chk({name, "_we"}, mem_we_o, v.wr);
                chk({name, "_wdata"}, mem_wdata_o, v.wdata);
                if (reqs == v.waits + 1) begin
                    mem_ready_i = 1'b1;
                    mem_rdata_i = v.rdata;
                end
                if (v.poke && reqs == 1) begin
                    start_i    = 1'b1;
                    write_en_i = ~v.wr;
                end
            end
            if (done_o) begin
                dones++;
                done_cyc = cyc;
                if (v.poke) start_i = 1'b1;
            end
            @(negedge clk_i);
            start_i = 1'b0;
            cyc++;
        end
        mem_ready_i = 1'b0;
        chk({name, "_busy_after"}, busy_o, 1'b0);
        for (int k = 0; k < 2; k++) begin
            if (done_o) dones++;
            if (mem_req_o) reqs++;
            @(negedge clk_i);
        end
        chk({name, "_req_cycles"}, reqs, exp_reqs);
        chk({name, "_done_cycle"}, done_cyc, exp_reqs + 1);
        chk({name, "_done_count"}, dones, 1);
        chk({name, "_ir"}, ir_o, v.exp_ir);
        chk({name, "_mdr"}, mdr_o, v.exp_mdr);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_req"}, mem_req_o, 1'b0);
        chk({name, "_we"}, mem_we_o, 1'b0);
        chk({name, "_done"}, done_o, 1'b0);
        chk({name, "_busy"}, busy_o, 1'b0);
        chk({name, "_addr"}, mem_addr_o, 16'h0);
        chk({name, "_wdata"}, mem_wdata_o, 16'h0);
        chk({name, "_ir"}, ir_o, 16'h0);
        chk({name, "_mdr"}, mdr_o, 16'h0);
    endtask

    initial begin
        vec_t v;
        tbl[0] = '{1'b0, 1'b1, 16'h0040, 16'h0000, 16'hA5C3, 0, 1'b0, 1'b0, 16'hA5C3, 16'h0000};
        tbl[1] = '{1'b0, 1'b0, 16'h1234, 16'h0000, 16'hBEEF, 3, 1'b0, 1'b0, 16'hA5C3, 16'hBEEF};
        tbl[2] = '{1'b1, 1'b1, 16'h00FF, 16'h5555, 16'h1111, 1, 1'b0, 1'b1, 16'hA5C3, 16'hBEEF};
        tbl[3] = '{1'b0, 1'b1, 16'h0002, 16'h0000, 16'h0F0F, 2, 1'b1, 1'b0, 16'h0F0F, 16'hBEEF};

        rst_ni      = 1'b0;
        addr_i      = '0;
        start_i     = 1'b0;
        is_fetch_i  = 1'b0;
        write_en_i  = 1'b0;
        wr_data_i   = '0;
        mem_rdata_i = '0;
        mem_ready_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk_all_zero("reset");
`ifdef MEM_TIMEOUT_EN
        chk("reset_err", err_o, 1'b0);
`endif
        rst_ni = 1'b1;

        for (int i = 0; i < 4; i++) begin
            run_txn(tbl[i], $sformatf("vec%0d", i));
        end
        exp_ir  = 16'h0F0F;
        exp_mdr = 16'hBEEF;

        // Reset during ACCESS must drop the request at once and clear IR/MDR.
        @(negedge clk_i);
        addr_i     = 16'h0777;
        wr_data_i  = 16'h3C3C;
        write_en_i = 1'b1;
        start_i    = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        chk("midrst_req_before", mem_req_o, 1'b1);
        #2 rst_ni = 1'b0;
        #1 chk_all_zero("midrst");
        exp_ir  = '0;
        exp_mdr = '0;
        @(negedge clk_i);
        mem_ready_i = 1'b1;
        mem_rdata_i = 16'hDEAD;
        rst_ni      = 1'b1;
        @(negedge clk_i);
        mem_ready_i = 1'b0;
        chk("release_busy", busy_o, 1'b0);
        chk("release_ir", ir_o, 16'h0);
        chk("release_mdr", mdr_o, 16'h0);

`ifdef MEM_TIMEOUT_EN
        exp_mdr = 16'h7777;
        v = '{1'b0, 1'b0, 16'h0100, 16'h0, 16'h7777, TMO - 1, 1'b0, 1'b0, exp_ir, exp_mdr};
        run_txn(v, "tmo_edge");
        chk("tmo_edge_err", err_o, 1'b0);
        v = '{1'b0, 1'b1, 16'h0200, 16'h0, 16'h9999, -1, 1'b0, 1'b0, exp_ir, exp_mdr};
        run_txn(v, "tmo_abort");
        chk("tmo_abort_err", err_o, 1'b1);
        exp_ir = 16'h4242;
        v = '{1'b0, 1'b1, 16'h0300, 16'h0, 16'h4242, 0, 1'b0, 1'b0, exp_ir, exp_mdr};
        run_txn(v, "tmo_sticky");
        chk("tmo_sticky_err", err_o, 1'b1);
`endif

        for (int i = 0; i < 40; i++) begin
            int r;
            r       = $urandom_range(0, 2);
            v.wr    = (r == 2);
            v.fetch = (r == 0) ? 1'b1 : (r == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            v.addr  = 16'($urandom);
            v.wdata = 16'($urandom);
            v.rdata = 16'($urandom);
            v.waits = $urandom_range(0, 4);
            v.poke  = ($urandom_range(0, 3) == 0);
            v.idle_rdy = 1'($urandom_range(0, 1));
            if (r == 0) exp_ir = v.rdata;
            if (r == 1) exp_mdr = v.rdata;
            v.exp_ir  = exp_ir;
            v.exp_mdr = exp_mdr;
            run_txn(v, $sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sits directly downstream of the IorD address mux in the 16-bit multicycle datapath.
- Takes the selected address (PC or ALU result) and runs one memory transaction per start pulse over a req/ready handshake.
- Reads capture into the Instruction Register (IR) or the Memory Data Register (MDR); writes drive store data out.
- Gives the control FSM a busy/done status pair.

Parameters:
- ADDR_W, 16, address width (matches the IorD mux output).
- DATA_W, 16, memory word width.
- TIMEOUT_CYC, 15, maximum cycles waiting for mem_ready (used only with the optional feature).

Ports:
- CLK  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- addr_in  input  ADDR_W  address from the IorD mux.
- start  input  1  one-cycle request from the control FSM.
- is_fetch  input  1  1 = instruction read into IR; 0 = data access.
- write_en  input  1  1 = store; overrides is_fetch.
- wr_data  input  DATA_W  store data.
- mem_addr  output  ADDR_W  registered address to memory.
- mem_req  output  1  request, held until accepted.
- mem_we  output  1  write strobe, valid while mem_req=1.
- mem_wdata  output  DATA_W  registered store data.
- mem_rdata  input  DATA_W  read data, valid when mem_ready=1.
- mem_ready  input  1  memory accept/complete.
- ir_out  output  DATA_W  Instruction Register.
- mdr_out  output  DATA_W  Memory Data Register.
- busy  output  1  high in ACCESS and DONE.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; all outputs 0, including ir_out, mdr_out, mem_req, mem_we and done.
- Reset mid-access aborts the transaction; mem_req drops immediately.
- Nothing is captured on the cycle reset is released.
- IDLE:
  - start=1 latches addr_in, wr_data and op, where op = write if write_en, else fetch if is_fetch, else data read.
  - Next state is ACCESS.
  - mem_ready is ignored in IDLE.
- ACCESS:
  - mem_req=1; mem_we=1 for writes; mem_addr and mem_wdata come from the latched values.
  - On a rising edge with mem_req&mem_ready:
    - fetch: IR <= mem_rdata.
    - data read: MDR <= mem_rdata.
    - write: IR and MDR unchanged.
  - Next state is DONE.
- DONE: done=1 for exactly one cycle, mem_req=0, then IDLE.
- Latency: start in cycle N, mem_req high in N+1. If mem_ready is high in N+1, capture happens at the end of N+1 and done is high in N+2. This is the minimum of 2 cycles start-to-done.
- start while busy=1 is ignored, with no queuing; the control FSM must wait for done.
- IR and MDR hold their values indefinitely between captures. Both are visible combinationally from the register outputs.
- mem_addr and mem_wdata keep their last latched value in IDLE/DONE. Only mem_req qualifies them.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined:
  - A counter runs in ACCESS.
  - If TIMEOUT_CYC cycles elapse without mem_ready, the access aborts: IR and MDR are unchanged, the block goes to DONE and pulses done.
  - Sticky output err (1 bit) is set; it clears only on reset.
  - mem_ready arriving on the same cycle as the timeout counts as success.
- Undefined: no counter and no err port; ACCESS waits forever.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, ACCESS, DONE), 2 bits;
  - the op enum (OP_FETCH, OP_READ, OP_WRITE);
  - the ADDR_W/DATA_W width constants shared with the datapath.
- Sub-module: the team's existing shared register block, instantiated twice (IR and MDR) with enables driven by the FSM capture strobe.
- FSM, request latch and timeout counter stay in this module.

Test Plan:
- Reset then idle: assert reset=0 mid-run -> all outputs 0, mem_req drops immediately; release -> IDLE, ir_out=0, mdr_out=0.
- Fetch, zero wait: addr_in=0x0040, is_fetch=1, start; mem_ready=1 with mem_rdata=0xA5C3 on the first req cycle -> mem_addr=0x0040, ir_out=0xA5C3, done 2 cycles after start, mdr_out unchanged.
- Data read, 3 wait cycles: addr_in=0x1234, is_fetch=0 -> mem_req held 4 cycles, mdr_out=mem_rdata (0xBEEF), ir_out unchanged.
- Write with is_fetch=1: write_en=1, wr_data=0x5555, addr_in=0x00FF -> mem_we=1, mem_wdata=0x5555, IR and MDR unchanged, done pulses once.
- start during busy and mem_ready in IDLE: second start mid-ACCESS -> ignored, exactly one done; mem_ready=1 while IDLE -> no capture.
- MEM_TIMEOUT_EN: mem_ready never asserted -> done after TIMEOUT_CYC=15 wait cycles, err=1 and sticky, IR/MDR unchanged; ready on cycle 15 -> success, err stays 0.
